pulse_period_monitor: RTL and testbench

//  Receive end of the 10 Hz strobe link: samples an asynchronous pulse on a Pmod input pin
//  (e.g. J1_IO7 of a peer board), measures edge-to-edge period in C cycles, checks it against
//  an expected period +/- tolerance, and declares lock after N consecutive good periods.

---
 rtl/pulse_period_monitor.sv | 163 ++++++++++++++++
 tb/tb_pulse_period_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_monitor.sv
// Receive end of the 10 Hz strobe link. Synchronises an asynchronous pulse
// input, measures the rising-edge to rising-edge period in clock cycles,
// checks each period against EXPECTED +/- TOL, and declares lock after
// LOCK_COUNT consecutive good periods. A missing edge for TIMEOUT_CYC cycles
// drops the link back to IDLE.
//
// Output protocol: EDGE, PERIOD_VALID and TIMEOUT are single-cycle pulses
// with no back-pressure; PERIOD and IN_TOL hold their last value until the
// next PERIOD_VALID; LOCKED is a level. DBG_STATE exposes the FSM state
// (0 = IDLE, 1 = MEASURE, 2 = LOCKED).
module pulse_period_monitor #(
    parameter int CNT_W       = 18,
    parameter int EXPECTED    = 100000,
    parameter int TOL         = 100,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic             C,
    input  logic             R,
    input  logic             PIN,
    output logic             EDGE,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             IN_TOL,
    output logic             LOCKED,
    output logic             TIMEOUT,
    output logic [1:0]       DBG_STATE
);

    localparam int GC_W = $clog2(LOCK_COUNT + 1);

    // Tolerance window as constants so no runtime subtraction is needed.
    localparam logic [CNT_W:0]   LO_BOUND = (CNT_W+1)'(EXPECTED - TOL);
    localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [GC_W-1:0]  LOCK_N   = GC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_hist;
    logic             r_edge;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [GC_W-1:0]  r_good;
    logic [CNT_W-1:0] r_period;
    logic             r_pv;
    logic             r_in_tol;
    logic             r_locked;
    logic             r_timeout;

    logic [CNT_W:0]   w_period_ext;
    logic [CNT_W-1:0] w_period;
    logic             w_in_tol;
    logic [GC_W-1:0]  w_good_inc;
    logic             w_timeout_hit;

    // Period is cnt+1; if the counter has saturated, report the saturated value.
    assign w_period_ext  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_period      = (r_cnt == CNT_MAX) ? CNT_MAX : w_period_ext[CNT_W-1:0];
    assign w_in_tol      = ({1'b0, w_period} >= LO_BOUND) && ({1'b0, w_period} <= HI_BOUND);
    assign w_good_inc    = r_good + GC_W'(1);
    assign w_timeout_hit = (r_cnt == TO_LAST);

    // Two-flop synchroniser, history flop and registered rising-edge pulse.
    always_ff @(posedge C) begin
        if (R) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_s1   <= PIN;
            r_s2   <= r_s1;
            r_hist <= r_s2;
            r_edge <= r_s2 & ~r_hist;
        end
    end

    // Cycles since the last edge; runs only while a reference edge exists, saturates.
    always_ff @(posedge C) begin
        if (R) begin
            r_cnt <= '0;
        end else if (r_edge) begin
            r_cnt <= '0;
        end else if ((r_state != ST_IDLE) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Lock FSM with registered period/tolerance/lock/timeout outputs.
    always_ff @(posedge C) begin
        if (R) begin
            r_state   <= ST_IDLE;
            r_good    <= '0;
            r_period  <= '0;
            r_pv      <= 1'b0;
            r_in_tol  <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pv      <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // First edge only establishes the reference point.
                    if (r_edge) begin
                        r_state <= ST_MEASURE;
                        r_good  <= '0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    // An edge takes priority over a coincident timeout.
                    if (r_edge) begin
                        r_period <= w_period;
                        r_in_tol <= w_in_tol;
                        r_pv     <= 1'b1;
                        if (w_in_tol) begin
                            if (r_state == ST_MEASURE) begin
                                if (w_good_inc == LOCK_N) begin
                                    r_state  <= ST_LOCKED;
                                    r_locked <= 1'b1;
                                    r_good   <= LOCK_N;
                                end else begin
                                    r_good <= w_good_inc;
                                end
                            end
                        end else begin
                            r_state  <= ST_MEASURE;
                            r_good   <= '0;
                            r_locked <= 1'b0;
                        end
                    end else if (w_timeout_hit) begin
                        r_state   <= ST_IDLE;
                        r_good    <= '0;
                        r_locked  <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_good   <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign EDGE         = r_edge;
    assign PERIOD       = r_period;
    assign PERIOD_VALID = r_pv;
    assign IN_TOL       = r_in_tol;
    assign LOCKED       = r_locked;
    assign TIMEOUT      = r_timeout;
    assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor with scaled-down parameters. A behavioural
// model tracks edge times and derives period, tolerance, lock and timeout
// from them; one compare process checks every cycle, and directed phases add
// hand-computed literal expectations.
module tb_pulse_period_monitor;

  localparam int CNT_W  = 10;
  localparam int EXP    = 100;
  localparam int TOL    = 5;
  localparam int LOCK_N = 4;
  localparam int TO_CYC = 200;
  localparam int P_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pin;
  logic             edge_o;
  logic [CNT_W-1:0] period_o;
  logic             pv_o;
  logic             in_tol_o;
  logic             locked_o;
  logic             timeout_o;
  logic [1:0]       state_o;

  int checks   = 0;
  int failures = 0;

  pulse_period_monitor #(
    .CNT_W      (CNT_W),
    .EXPECTED   (EXP),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_N),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .C           (clk),
    .R           (rst),
    .PIN         (pin),
    .EDGE        (edge_o),
    .PERIOD      (period_o),
    .PERIOD_VALID(pv_o),
    .IN_TOL      (in_tol_o),
    .LOCKED      (locked_o),
    .TIMEOUT     (timeout_o),
    .DBG_STATE   (state_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples delayed through the synchroniser; edges are time-stamped and
  // the period is the difference of consecutive edge stamps.
  int m_d1 = 0, m_d2 = 0, m_d3 = 0;
  int m_edge = 0, m_pv = 0, m_to = 0, m_locked = 0, m_in_tol = 0;
  int m_have_ref = 0, m_good = 0, m_period = 0;
  int m_cyc = 0, m_last = 0;

  task automatic model_step();
    int p;
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_d3 = 0;
      m_edge = 0; m_pv = 0; m_to = 0; m_locked = 0; m_in_tol = 0;
      m_have_ref = 0; m_good = 0; m_period = 0;
    end else begin
      m_pv = 0;
      m_to = 0;
      if (m_edge != 0) begin
        if (m_have_ref != 0) begin
          p = m_cyc - m_last;
          if (p > P_MAX) p = P_MAX;
          m_period = p;
          m_in_tol = (p >= EXP - TOL && p <= EXP + TOL) ? 1 : 0;
          m_pv = 1;
          if (m_in_tol != 0) begin
            if (m_good < LOCK_N) m_good++;
            if (m_good == LOCK_N) m_locked = 1;
          end else begin
            m_good = 0;
            m_locked = 0;
          end
        end else begin
          m_have_ref = 1;
          m_good = 0;
        end
        m_last = m_cyc;
      end else if (m_have_ref != 0 && (m_cyc - m_last) == TO_CYC) begin
        m_have_ref = 0;
        m_locked = 0;
        m_good = 0;
        m_to = 1;
      end
      // rising edge of the pin as seen three clock edges after sampling
      m_edge = (m_d2 != 0 && m_d3 == 0) ? 1 : 0;
      m_d3 = m_d2;
      m_d2 = m_d1;
      m_d1 = pin ? 1 : 0;
    end
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- compare process + event counters ----------------
  int cmp_on = 0;
  int cyc = 0;
  int pv_count = 0, to_count = 0, edge_count = 0;
  int last_pv_cyc = 0, last_to_cyc = 0;
  int first_lock_pv = -1;
  logic prev_locked = 1'b0;

  initial begin
    int m_state;
    @(posedge clk);
    cmp_on = 1;
    forever begin
      @(negedge clk);
      cyc++;
      m_state = (m_have_ref == 0) ? 0 : ((m_locked != 0) ? 2 : 1);
      check("edge", edge_o, m_edge);
      check("period_valid", pv_o, m_pv);
      check("timeout", timeout_o, m_to);
      check("locked", locked_o, m_locked);
      check("in_tol", in_tol_o, m_in_tol);
      check("period", period_o, m_period);
      check("state", state_o, m_state);
      if (pv_o) begin pv_count++; last_pv_cyc = cyc; end
      if (timeout_o) begin to_count++; last_to_cyc = cyc; end
      if (edge_o) edge_count++;
      if (locked_o && !prev_locked && first_lock_pv < 0) first_lock_pv = pv_count;
      prev_locked = locked_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Rising edge now, high 2 cycles, next rising edge p cycles later.
  task automatic pulse(input int p);
    pin = 1'b1;
    repeat (2) @(negedge clk);
    pin = 1'b0;
    repeat (p - 2) @(negedge clk);
  endtask

  task automatic chk_meas(input string tag, input int per, input int tol, input int lck);
    #1;
    check({tag, "_period"}, period_o, per);
    check({tag, "_in_tol"}, in_tol_o, tol);
    check({tag, "_locked"}, locked_o, lck);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pv0, to0, ec0, n;
    rst = 1'b1;
    pin = 1'b0;

    // Reset with pin toggling: everything held at zero.
    repeat (3) begin
      @(negedge clk);
      pin = ~pin;
      #1;
      check("rst_edge", edge_o, 0);
      check("rst_locked", locked_o, 0);
      check("rst_period", period_o, 0);
      check("rst_pv", pv_o, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    pin = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_no_edge", edge_count, 0);

    // Six nominal pulses: 5 periods, lock on the 4th report (5th edge).
    repeat (6) pulse(100);
    chk_meas("nominal", 100, 1, 1);
    check("nominal_pv_count", pv_count, 5);
    check("lock_at_pv", first_lock_pv, 4);

    // Tolerance bounds (95..105 inclusive).
    pulse(95);
    pulse(105);  chk_meas("lo_bound", 95, 1, 1);
    pulse(94);   chk_meas("hi_bound", 105, 1, 1);
    pulse(106);  chk_meas("below_lo", 94, 0, 0);
    pulse(100);  chk_meas("above_hi", 106, 0, 0);
    repeat (3) pulse(100);
    chk_meas("three_good", 100, 1, 0);
    pulse(150);  chk_meas("relocked", 100, 1, 1);

    // One long period while locked, then relock after 4 good periods.
    pulse(100);  chk_meas("long_unlock", 150, 0, 0);
    repeat (3) pulse(100);
    chk_meas("relock_pending", 100, 1, 0);
    pulse(100);  chk_meas("relock", 100, 1, 1);

    // Pin stuck low: timeout exactly TO_CYC cycles after the last report.
    to0 = to_count;
    n = 0;
    while (to_count == to0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("timeout_seen", to_count - to0, 1);
    check("timeout_gap", last_to_cyc - last_pv_cyc, TO_CYC);
    check("timeout_locked", locked_o, 0);
    check("timeout_state", state_o, 0);
    check("timeout_period_hold", period_o, 100);

    // First edge after timeout gives no report; the next one does.
    pv0 = pv_count;
    pulse(100);
    #1;
    check("no_pv_after_timeout", pv_count - pv0, 0);
    pulse(200);
    #1;
    check("pv_after_ref", pv_count - pv0, 1);
    check("period_after_ref", period_o, 100);

    // Edge exactly at the timeout threshold wins; one cycle later times out.
    to0 = to_count;
    pulse(201);  chk_meas("edge_wins", 200, 0, 0);
    check("edge_wins_no_timeout", to_count - to0, 0);
    pv0 = pv_count;
    pulse(100);
    #1;
    check("late_edge_timeout", to_count - to0, 1);
    check("late_edge_no_pv", pv_count - pv0, 0);

    // Relock, then reset mid-period with pin high at release.
    repeat (5) pulse(100);
    chk_meas("pre_reset", 100, 1, 1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    pin = 1'b1;
    @(negedge clk);
    chk_meas("in_reset", 0, 0, 0);
    repeat (2) @(negedge clk);
    ec0 = edge_count;
    pv0 = pv_count;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pin = 1'b0;
    repeat (98) @(negedge clk);
    #1;
    check("release_one_edge", edge_count - ec0, 1);
    check("release_no_pv", pv_count - pv0, 0);
    pulse(100);
    #1;
    check("release_next_pv", pv_count - pv0, 1);
    check("release_period", period_o, 100);

    repeat (5) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
